// File: rtl/dff_arb_pkg.sv
// Shared types, constants and the rotating first-set search used by dff_rr_arbiter.
// Supports up to eight requesters; the search works on a zero-padded 8-bit vector.
package dff_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic [7:0]  ARB_IDLE_GNT = '0;
    localparam int unsigned RST_PTR      = 0;

    // Returns {found, index}: first set bit of req at or above ptr, wrapping modulo num.
    function automatic logic [3:0] rot_first_set(
        input logic [7:0] req,
        input logic [3:0] num,
        input logic [2:0] ptr
    );
        logic [3:0] idx;
        logic       found;
        logic [2:0] win;
        found = 1'b0;
        win   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= num) begin
                idx = idx - num;
            end else begin
                idx = idx;
            end
            if (!found && (4'(k) < num) && req[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

endpackage

// File: rtl/dff_arb_pick.sv
// Combinational winner search: first requester at or above the pointer, skipping
// any requester flagged in the exclude mask.
module dff_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] excl,
    output logic [PTR_W-1:0]   win,
    output logic               found
);
    import dff_arb_pkg::*;

    logic [7:0] cand_s;
    logic [2:0] ptr_s;
    logic [3:0] res_s;

    // Pad to the package search width and split the packed result.
    always_comb begin
        cand_s = 8'(req & ~excl);
        ptr_s  = 3'(ptr);
        res_s  = rot_first_set(cand_s, 4'(NUM_REQ), ptr_s);
        found  = res_s[3];
        win    = PTR_W'(res_s[2:0]);
    end

endmodule

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter driving an N:1 mux into a registered output stage.
// Define DFF_ARB_FIXED_PRIO_EN for fixed lowest-index-first arbitration instead.
module dff_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_in,
    input  logic [NUM_REQ*DATA_W-1:0]   din_in,
    output logic [NUM_REQ-1:0]          grant_out,
    output logic [$clog2(NUM_REQ)-1:0]  sel_out,
    output logic [DATA_W-1:0]           q_out,
    output logic                        valid_out
);
    import dff_arb_pkg::*;

    localparam int                PTR_W    = $clog2(NUM_REQ);
    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_BURST);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(RST_PTR);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GNT_IDLE = ARB_IDLE_GNT[NUM_REQ-1:0];

    arb_state_t         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   next_ptr_s;
    logic [PTR_W-1:0]   pick_ptr_s;
    logic [PTR_W-1:0]   win_s;
    logic [NUM_REQ-1:0] excl_s;
    logic               expire_s;
    logic               release_s;
    logic               found_s;

    // Release detection and the pointer/exclude inputs for this cycle's arbitration.
    always_comb begin
        expire_s  = (state_r == GRANT) && (cnt_r == MAX_CNT);
        release_s = (state_r == GRANT) && (!req_in[sel_out] || expire_s);
        if (expire_s) begin
            excl_s = ONE_HOT0 << sel_out;
        end else begin
            excl_s = '0;
        end
`ifdef DFF_ARB_FIXED_PRIO_EN
        next_ptr_s = PTR_RST;
`else
        if (sel_out == PTR_LAST) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = sel_out + PTR_W'(1);
        end
`endif
        // On release the search starts just past the outgoing grantee.
        if (state_r == GRANT) begin
            pick_ptr_s = next_ptr_s;
        end else begin
            pick_ptr_s = ptr_r;
        end
    end

    dff_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req_in),
        .ptr   (pick_ptr_s),
        .excl  (excl_s),
        .win   (win_s),
        .found (found_s)
    );

    // Arbitration FSM: grant, select, burst counter and rotation pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            ptr_r     <= PTR_RST;
            grant_out <= GNT_IDLE;
            sel_out   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r   <= GRANT;
                        grant_out <= ONE_HOT0 << win_s;
                        sel_out   <= win_s;
                        cnt_r     <= 4'd1;
                    end else begin
                        state_r   <= IDLE;
                        grant_out <= GNT_IDLE;
                    end
                end
                GRANT: begin
                    if (release_s) begin
                        ptr_r <= next_ptr_s;
                        if (found_s) begin
                            state_r   <= GRANT;
                            grant_out <= ONE_HOT0 << win_s;
                            sel_out   <= win_s;
                            cnt_r     <= 4'd1;
                        end else begin
                            state_r   <= IDLE;
                            grant_out <= GNT_IDLE;
                            cnt_r     <= '0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    ptr_r     <= PTR_RST;
                    grant_out <= GNT_IDLE;
                    sel_out   <= '0;
                end
            endcase
        end
    end

    // Output stage: capture only while the grantee is still requesting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_out     <= '0;
            valid_out <= 1'b0;
        end else if (|(grant_out & req_in)) begin
            q_out     <= din_in[sel_out*DATA_W +: DATA_W];
            valid_out <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Self-checking bench for dff_rr_arbiter (NUM_REQ=4, DATA_W=1, MAX_BURST=4).
module tb_dff_rr_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] grant_out;
    logic [1:0] sel_out;
    logic       q_out;
    logic       valid_out;
    logic [7:0] obs;

    int checks;
    int failures;

    // Reference model state
    logic       m_busy;
    int         m_cnt;
    int         m_ptr;
    int         m_sel;
    logic [3:0] m_grant;
    logic       m_q;
    logic       m_valid;
    logic [7:0] sb_q[$];

    dff_rr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (1),
        .MAX_BURST (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req),
        .din_in    (din),
        .grant_out (grant_out),
        .sel_out   (sel_out),
        .q_out     (q_out),
        .valid_out (valid_out)
    );

    assign obs = {grant_out, sel_out, q_out, valid_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_cnt   = 0;
        m_ptr   = 0;
        m_sel   = 0;
        m_grant = 4'b0000;
        m_q     = 1'b0;
        m_valid = 1'b0;
        sb_q.delete();
    endtask

    // Advance the model by one edge with the current inputs and queue the expectation.
    task automatic model_step(input logic [3:0] r, input logic [3:0] d);
        logic [3:0] cand;
        int         start;
        int         pick;
        int         idx;
        logic       nq;
        logic       nv;
        if ((m_grant & r) != 4'b0000) begin
            nq = d[m_sel];
            nv = 1'b1;
        end else begin
            nq = m_q;
            nv = 1'b0;
        end
        cand  = r;
        pick  = -1;
        start = m_ptr;
        if (m_busy) begin
            if (r[m_sel] && (m_cnt < MAXB)) begin
                m_cnt = m_cnt + 1;
                start = -1;
            end else begin
                if (m_cnt == MAXB) cand[m_sel] = 1'b0;
`ifdef DFF_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (m_sel + 1) % N;
`endif
                start = m_ptr;
            end
        end
        if (start >= 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (start + k) % N;
                if (pick < 0 && cand[idx]) pick = idx;
            end
            if (pick >= 0) begin
                m_busy  = 1'b1;
                m_sel   = pick;
                m_cnt   = 1;
                m_grant = 4'b0001 << pick;
            end else begin
                m_busy  = 1'b0;
                m_cnt   = 0;
                m_grant = 4'b0000;
            end
        end
        m_q     = nq;
        m_valid = nv;
        sb_q.push_back({m_grant, 2'(m_sel), m_q, m_valid});
    endtask

    task automatic tick();
        model_step(req, din);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = 4'b0000;
        din = 4'b0000;
        @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b0;
        req = 4'b0000;
        din = 4'b0000;
        #3;
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 8'h00);
        end
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_sb cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            checks++;
            if ({grant_out, q_out, valid_out} !== 6'b000000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=000000", k, {grant_out, q_out, valid_out});
            end
        end
    endtask

    task automatic test_lone();
        logic [7:0] exp;
        logic [3:0] tab [8];
        tab = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
        do_reset();
        req = 4'b0100;
        din = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL lone_sb cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            checks++;
            if (grant_out !== tab[k]) begin
                failures++;
                $display("FAIL lone_grant cyc=%0d got=%b exp=%b", k, grant_out, tab[k]);
            end
        end
    endtask

    task automatic test_first_valid();
        do_reset();
        req = 4'b0100;
        din = 4'b0100;
        tick();
        void'(sb_q.pop_front());
        checks++;
        if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got=%b exp=0", valid_out);
        end
        tick();
        void'(sb_q.pop_front());
        checks++;
        if ({valid_out, q_out} !== 2'b11) begin
            failures++;
            $display("FAIL latency_valid got=%b exp=11", {valid_out, q_out});
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp;
        int         es;
        do_reset();
        req = 4'b1111;
        din = 4'b1010;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp = sb_q.pop_front();
`ifdef DFF_ARB_FIXED_PRIO_EN
            es = (k / 4) % 2;
`else
            es = (k / 4) % 4;
`endif
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rotate_sb cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            checks++;
            if ({grant_out, sel_out} !== {4'b0001 << es, 2'(es)}) begin
                failures++;
                $display("FAIL rotate_grant cyc=%0d got=%b/%0d exp_sel=%0d", k, grant_out, sel_out, es);
            end
            if (k >= 1) begin
                checks++;
                if (valid_out !== 1'b1) begin
                    failures++;
                    $display("FAIL rotate_bubble cyc=%0d got=%b exp=1", k, valid_out);
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [7:0] exp;
        do_reset();
        req = 4'b1010;
        din = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req = 4'b1000;
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL drop_sb cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            if (k == 2) begin
                checks++;
                if ({grant_out, valid_out, q_out} !== 6'b100001) begin
                    failures++;
                    $display("FAIL drop_switch got=%b exp=100001", {grant_out, valid_out, q_out});
                end
            end
            if (k == 3) begin
                checks++;
                if ({valid_out, q_out} !== 2'b10) begin
                    failures++;
                    $display("FAIL drop_next got=%b exp=10", {valid_out, q_out});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        do_reset();
        req = 4'b0100;
        din = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rmid_sb cyc=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL rmid_async got=%b exp=%b", obs, 8'h00);
        end
        @(negedge clk);
        model_reset();
        req = 4'b0101;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rmid_after cyc=%0d got=%b exp=%b", k, obs, exp);
            end
        end
        checks++;
        if (grant_out !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_first got=%b exp=0001", grant_out);
        end
    endtask

    task automatic test_pair();
        logic [7:0] exp;
        int         tab [9];
        tab = '{1, 1, 1, 1, 3, 3, 3, 3, 1};
        do_reset();
        req = 4'b1010;
        din = 4'b1000;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL pair_sb cyc=%0d got=%b exp=%b", k, obs, exp);
            end
            checks++;
            if (grant_out !== (4'b0001 << tab[k])) begin
                failures++;
                $display("FAIL pair_grant cyc=%0d got=%b exp_idx=%0d", k, grant_out, tab[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            din = 4'($urandom_range(0, 15));
            tick();
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random_sb cyc=%0d req=%b got=%b exp=%b", k, req, obs, exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        req      = 4'b0000;
        din      = 4'b0000;
        model_reset();
        test_reset();
        test_first_valid();
        test_lone();
        test_rotate();
        test_drop();
        test_reset_mid();
        test_pair();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_rr_arbiter.md
Name: dff_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared registered data path: an N:1 select mux feeding a synchronously captured output register.
- Requesters raise req_in and get exclusive use of the path for a bounded burst.
- The block drives the mux select, returns a one-hot grant to each requester, and registers the selected data with a valid qualifier.
- Sits between several producer blocks and one single-cycle-delay output stage.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 1, width of each requester's data word.
- MAX_BURST, 4, maximum cycles one grant may be held; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- req_in  input  NUM_REQ  per-requester request, level-sensitive.
- din_in  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- grant_out  output  NUM_REQ  registered one-hot grant, or all-zero.
- sel_out  output  $clog2(NUM_REQ)  registered index of the current grantee.
- q_out  output  DATA_W  registered selected data.
- valid_out  output  1  high when q_out was captured from a granted, requesting source on the previous edge.

Behaviour:
- Reset (rst low, asynchronous):
  - grant_out=0, sel_out=0, q_out=0, valid_out=0.
  - State IDLE, burst counter 0, round-robin pointer 0 (requester 0 has highest priority first).
  - Release is synchronous to clk.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_in bit is high, the winner is the first requesting index at or above the pointer, wrapping modulo NUM_REQ.
  - Next edge: grant_out = onehot(winner), sel_out = winner, counter = 1, state = GRANT.
  - With no requests, stay in IDLE.
- GRANT, grantee g:
  - Release condition: req_in[g]==0 OR counter==MAX_BURST.
  - On release, the pointer becomes g+1 mod NUM_REQ and arbitration reruns in the same cycle over the current req_in, with g excluded when counter==MAX_BURST.
  - Winner found: new grant on the next edge with no idle bubble; counter reloads to 1.
  - No winner: go to IDLE with grant_out=0.
  - With no release, the counter increments.
  - A lone requester that hits MAX_BURST while still requesting loses its grant for exactly one cycle (IDLE), then is regranted.
- Data capture, every edge:
  - If |(grant_out & req_in), then q_out <= din_in[sel_out] and valid_out <= 1.
  - Otherwise valid_out <= 0 and q_out holds its value.
  - Latency from req_in rising in IDLE to first valid_out: 2 cycles.
- A requester sees its grant and must hold din_in stable while req_in && grant_out.
- A requester dropping req_in mid-grant gets no capture in that cycle.
- Simultaneous requests resolve purely through the pointer; there are no ties.
- A req_in change in the same cycle as a release is seen by that arbitration.
- Reset mid-burst aborts immediately and the pointer returns to 0.
- Bits of req_in at or above NUM_REQ do not exist; sel_out never exceeds NUM_REQ-1.

Optional Feature:
- DFF_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority, lowest requesting index wins.
  - The pointer is unused and stays 0.
  - MAX_BURST release still applies, and the expiring grantee is still excluded for that one arbitration.
- When undefined, round-robin behaves as above.

Decomposition:
- Shared package dff_arb_pkg:
  - state enum {IDLE, GRANT};
  - constants ARB_IDLE_GNT='0 and RST_PTR=0;
  - a function returning the rotating first-set index.
- One natural sub-module, dff_arb_pick: purely combinational.
  - Inputs: req vector, pointer, exclude mask.
  - Outputs: winner index and found flag.
- FSM, counter, pointer and output register stay in the top module.

Test Plan:
- Reset release, req_in=4'b0000 for 5 cycles -> grant_out=0, valid_out=0, q_out=0 throughout.
- req_in=4'b0100 held, din[2]=1, MAX_BURST=4:
  - grant_out=4'b0100 one cycle after the request, valid_out=1 the cycle after that, q_out=1.
  - After 4 grant cycles, one IDLE cycle, then regrant.
- req_in=4'b1111 held:
  - Grants rotate 0,1,2,3,0, each lasting 4 cycles, with no bubble between grants.
  - sel_out matches the grantee.
- Requester 1 granted, drops req after 2 cycles while req 3 is high -> grant_out goes 4'b0010 to 4'b1000 on the next edge, and valid_out=0 for the dropped cycle.
- rst asserted low mid-burst with requester 2 granted -> all outputs 0 immediately (asynchronous). After release with req_in=4'b0101, requester 0 is granted first.
- With DFF_ARB_FIXED_PRIO_EN defined, req_in=4'b1010 held -> requester 1 is granted, then requester 3 for one burst when 1 is excluded at expiry, then requester 1 again.
